tmp101_fahrenheit_display: RTL and testbench

Downstream consumer of the TMP101 read stage. It periodically pulses that stage's Start input and captures ReceivedData on each DONE rising edge, treating the byte as signed integer °C. It converts the value to integer °F using a sequential divider and a double-dabble BCD converter, then drives the 4-digit multiplexed 7-segment display.

---
 rtl/tmp101_fahrenheit_display.sv | 168 ++++++++++++++++
 tb/tb_tmp101_fahrenheit_display.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tmp101_fahrenheit_display.sv
// TMP101 consumer: samples degC, converts to degF with a serial
// divider and double dabble, and scans a 4-digit 7-segment display.
module tmp101_fahrenheit_display #(
  parameter int SAMPLE_DIV  = 50_000_000,
  parameter int REFRESH_DIV = 100_000
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       DONE,
  input  logic [7:0] ReceivedData,
  output logic       Start,
  output logic       Valid,
  output logic [9:0] TempF,
  output logic [3:0] Anodes,
  output logic [6:0] Segments
);
  localparam int SW = $clog2(SAMPLE_DIV);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] MINUS = 7'h3F;

  typedef enum logic [2:0] {
    IDLE, START, WAIT, DIV, BCD, LOAD
  } state_t;

  state_t            state;
  logic [SW-1:0]     samp_cnt;
  logic [RW-1:0]     scan_cnt;
  logic [1:0]        idx;
  logic              pending;
  logic              done_d;
  logic              neg;
  logic [10:0]       quo;
  logic [2:0]        rem;
  logic [3:0]        step;
  logic [11:0]       bcd;
  logic [3:0][6:0]   digit;

  logic signed [11:0] c12;
  logic signed [11:0] n;
  logic [10:0]        mag;
  logic [3:0]         trial;
  logic               ge;
  logic [11:0]        badj;
  logic [8:0]         q9;
  logic               negf;

  function automatic logic [3:0] adj(input logic [3:0] x);
    return (x >= 4'd5) ? x + 4'd3 : x;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return BLANK;
    endcase
  endfunction

  // N = 9*C + 160 so that F = trunc(N / 5)
  assign c12   = {{4{ReceivedData[7]}}, ReceivedData};
  assign n     = (c12 <<< 3) + c12 + 12'sd160;
  assign mag   = n[11] ? 11'(-n) : n[10:0];
  assign trial = {rem, quo[10]};
  assign ge    = trial >= 4'd5;
  assign badj  = {adj(bcd[11:8]), adj(bcd[7:4]), adj(bcd[3:0])};
  assign q9    = quo[8:0];
  assign negf  = neg && (q9 != 9'd0);

  always_ff @(posedge clock) begin
    if (!Reset) begin
      state    <= IDLE;
      samp_cnt <= '0;
      scan_cnt <= '0;
      idx      <= 2'd0;
      pending  <= 1'b1;
      done_d   <= 1'b0;
      neg      <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      step     <= '0;
      bcd      <= '0;
      digit    <= {4{BLANK}};
      Start    <= 1'b0;
      Valid    <= 1'b0;
      TempF    <= '0;
      Anodes   <= 4'b1110;
      Segments <= BLANK;
    end else begin
      done_d <= DONE;
      Start  <= 1'b0;

      if (samp_cnt == SW'(SAMPLE_DIV - 1)) begin
        samp_cnt <= '0;
        pending  <= 1'b1;
      end else begin
        samp_cnt <= samp_cnt + 1'b1;
      end

      if (scan_cnt == RW'(REFRESH_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      Anodes   <= ~(4'b0001 << idx);
      Segments <= digit[idx];

      unique case (state)
        IDLE: begin
          if (pending) begin
            pending <= 1'b0;
            Start   <= 1'b1;
            state   <= START;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (!done_d && DONE) begin
            neg   <= n[11];
            quo   <= mag;
            rem   <= '0;
            step  <= '0;
            bcd   <= '0;
            state <= DIV;
          end
        end
        DIV: begin
          rem  <= ge ? 3'(trial - 4'd5) : trial[2:0];
          quo  <= {quo[9:0], ge};
          step <= step + 4'd1;
          if (step == 4'd10) begin
            step  <= '0;
            state <= BCD;
          end
        end
        BCD: begin
          // rotate so the quotient is intact again for LOAD
          bcd      <= {badj[10:0], quo[8]};
          quo[8:0] <= {quo[7:0], quo[8]};
          step     <= step + 4'd1;
          if (step == 4'd8) begin
            step  <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          TempF    <= neg ? -{1'b0, q9} : {1'b0, q9};
          Valid    <= 1'b1;
          digit[3] <= negf ? MINUS : BLANK;
          digit[2] <= (bcd[11:8] != 4'd0) ? seg7(bcd[11:8]) : BLANK;
          digit[1] <= (bcd[11:4] != 8'd0) ? seg7(bcd[7:4]) : BLANK;
          digit[0] <= seg7(bcd[3:0]);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tmp101_fahrenheit_display.sv
// Scoreboard bench for tmp101_fahrenheit_display: random and
// directed conversions against a plain-arithmetic degF model.
module tb_tmp101_fahrenheit_display;
  localparam int SAMPLE_DIV  = 32;
  localparam int REFRESH_DIV = 4;

  logic       clock = 1'b0;
  logic       Reset = 1'b0;
  logic       DONE = 1'b0;
  logic [7:0] ReceivedData = 8'h00;
  logic       Start;
  logic       Valid;
  logic [9:0] TempF;
  logic [3:0] Anodes;
  logic [6:0] Segments;

  tmp101_fahrenheit_display #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .REFRESH_DIV(REFRESH_DIV)
  ) dut (
    .clock(clock),
    .Reset(Reset),
    .DONE(DONE),
    .ReceivedData(ReceivedData),
    .Start(Start),
    .Valid(Valid),
    .TempF(TempF),
    .Anodes(Anodes),
    .Segments(Segments)
  );

  always #5 clock = ~clock;

  typedef struct {
    int k;
    int f;
    logic [3:0][6:0] d;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  int   disp_left = 0;
  int   prev_f = 0;
  int   start_cnt = 0;
  int   start_cyc = 0;
  bit   start_seen = 0;
  bit   prev_start = 0;
  logic [3:0] prev_an = 4'b1110;

  logic [6:0] seg_lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [7:0] c);
    exp_t e;
    int n, f, m, h, t, o;
    n = 9 * int'($signed(c)) + 160;
    f = n / 5;
    m = (f < 0) ? -f : f;
    h = m / 100;
    t = (m / 10) % 10;
    o = m % 10;
    e.k = 0;
    e.f = f;
    e.d[3] = (f < 0) ? 7'h3F : 7'h7F;
    e.d[2] = (h != 0) ? seg_lut[h] : 7'h7F;
    e.d[1] = (h != 0 || t != 0) ? seg_lut[t] : 7'h7F;
    e.d[0] = seg_lut[o];
    return e;
  endfunction

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  initial forever begin
    @(negedge clock);
    if (Start === 1'b1) begin
      chk("start_width", {31'b0, prev_start}, 0);
      start_cnt++;
      start_seen = 1;
      start_cyc = cyc;
    end
    prev_start = (Start === 1'b1);
  end

  initial forever begin
    @(negedge clock);
    if (disp_left > 0) begin
      int i;
      i = -1;
      for (int j = 0; j < 4; j++)
        if (Anodes === ~(4'b0001 << j)) i = j;
      chk("anode_onehot", {31'b0, i >= 0}, 1);
      if (i >= 0) chk("segments", Segments, cur.d[i]);
      if (disp_left < 4 * REFRESH_DIV && Anodes !== prev_an)
        chk("anode_order", Anodes, {prev_an[2:0], prev_an[3]});
      prev_an = Anodes;
      disp_left--;
    end
    if (q.size() > 0) begin
      if (cyc == q[0].k + 20)
        chk("tempf_before_load", $signed(TempF), prev_f);
      if (cyc == q[0].k + 21) begin
        cur = q.pop_front();
        chk("tempf", $signed(TempF), cur.f);
        chk("valid", Valid, 1);
        prev_f = cur.f;
        disp_left = 4 * REFRESH_DIV;
      end
    end
  end

  task automatic wait_start();
    int n;
    n = 0;
    while (!start_seen && n < 300) begin
      tick();
      n++;
    end
    chk("start_seen", {31'b0, start_seen}, 1);
    start_seen = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || disp_left != 0) && n < 400) begin
      tick();
      n++;
    end
    chk("scoreboard_drain", q.size(), 0);
  endtask

  task automatic raise_done(input logic [7:0] c, output exp_t e);
    e = model(c);
    ReceivedData = c;
    DONE = 1'b1;
    e.k = cyc + 1;
    q.push_back(e);
  endtask

  task automatic do_conv(input logic [7:0] c, input int d);
    exp_t e;
    wait_start();
    repeat (d) tick();
    raise_done(c, e);
    repeat (2) tick();
    DONE = 1'b0;
    wait_idle();
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    DONE = 1'b0;
    repeat (3) tick();
    chk("rst_start", Start, 0);
    chk("rst_valid", Valid, 0);
    chk("rst_tempf", $signed(TempF), 0);
    chk("rst_anodes", Anodes, 4'b1110);
    chk("rst_segments", Segments, 7'h7F);
    q.delete();
    disp_left = 0;
    prev_f = 0;
    start_seen = 0;
    Reset = 1'b1;
    tick();
    chk("start_after_reset", Start, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int fs, s0, k;
    do_reset();
    fs = start_cyc;
    do_conv(8'h19, 1);
    chk("sample_period", start_cyc - fs, SAMPLE_DIV);
    do_conv(8'hD8, 2);
    do_conv(8'hEE, 3);
    do_conv(8'h7F, 1);
    do_conv(8'h80, 2);

    // DONE held high across two periods: only one capture
    wait_start();
    repeat (2) tick();
    raise_done(8'h0A, e);
    s0 = start_cnt;
    repeat (2) tick();
    ReceivedData = 8'hF6;
    while (cyc < e.k + 80) tick();
    chk("hold_one_start", start_cnt - s0, 1);
    chk("hold_tempf", $signed(TempF), e.f);
    DONE = 1'b0;
    tick();
    do_conv(8'hF6, 2);

    // DONE late by three periods: one coalesced Start after LOAD
    wait_start();
    s0 = start_cnt;
    repeat (3 * SAMPLE_DIV) tick();
    chk("no_start_in_wait", start_cnt - s0, 0);
    raise_done(8'h05, e);
    repeat (2) tick();
    DONE = 1'b0;
    while (cyc < e.k + 22) tick();
    chk("extra_start", Start, 1);
    repeat (20) tick();
    chk("one_extra_start", start_cnt - s0, 1);
    wait_idle();

    repeat (20) do_conv(8'($urandom_range(0, 255)), $urandom_range(1, 6));

    // reset while dividing must not publish anything
    do_reset();
    tick();
    ReceivedData = 8'h19;
    DONE = 1'b1;
    k = cyc + 1;
    while (cyc < k + 5) tick();
    Reset = 1'b0;
    repeat (2) tick();
    Reset = 1'b1;
    DONE = 1'b0;
    start_seen = 0;
    repeat (40) begin
      tick();
      chk("rst_div_valid", Valid, 0);
      chk("rst_div_tempf", $signed(TempF), 0);
      chk("rst_div_blank", Segments, 7'h7F);
    end
    do_conv(8'h19, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
